// File: rtl/reservation_station.sv
// reservation_station: tag-tracking issue queue that snoops the ALU/memory CDBs and dispatches the lowest ready entry.
module reservation_station #(
    parameter int DEPTH     = 4,
    parameter int FULL_MARK = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  op_in,
    input  logic [31:0] value1_in,
    input  logic [31:0] value2_in,
    input  logic [2:0]  query1_in,
    input  logic [2:0]  query2_in,
    input  logic [31:0] imm_in,
    input  logic [2:0]  target_in,
    input  logic        is_branch_in,
    input  logic [2:0]  alu_num,
    input  logic [31:0] alu_value,
    input  logic        alu_branch,
    input  logic [2:0]  mem_num,
    input  logic [31:0] mem_value,
    output logic        rs_full,
    output logic [4:0]  ex_op,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [2:0]  ex_dest,
    output logic        ex_is_branch
);
    localparam logic [4:0] NOP = 5'b11111;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] busy, busy_n, br, br_n;
    logic [4:0]  op [DEPTH];
    logic [4:0]  op_n [DEPTH];
    logic [31:0] v1 [DEPTH];
    logic [31:0] v1_n [DEPTH];
    logic [31:0] v2 [DEPTH];
    logic [31:0] v2_n [DEPTH];
    logic [31:0] imm [DEPTH];
    logic [31:0] imm_n [DEPTH];
    logic [2:0]  q1 [DEPTH];
    logic [2:0]  q1_n [DEPTH];
    logic [2:0]  q2 [DEPTH];
    logic [2:0]  q2_n [DEPTH];
    logic [2:0]  dest [DEPTH];
    logic [2:0]  dest_n [DEPTH];
    logic          disp, found, iss_ok;
    logic [IW-1:0] d_idx, iss_idx;
    int            occ;

    // Memory result wins when both buses carry the same tag; branch outcomes on the ALU bus are not data.
    function automatic logic [34:0] snoop(input logic [2:0] q, input logic [31:0] v,
                                          input logic [2:0] an, input logic [31:0] av, input logic ab,
                                          input logic [2:0] mn, input logic [31:0] mv);
        return (mn != 3'd0 && q == mn) ? {3'd0, mv} :
               (an != 3'd0 && !ab && q == an) ? {3'd0, av} : {q, v};
    endfunction

    always_comb begin
        busy_n = busy;
        br_n   = br;
        op_n   = op;
        imm_n  = imm;
        dest_n = dest;
        disp   = 1'b0;
        d_idx  = '0;
        found  = 1'b0;
        iss_idx = '0;
        occ    = 0;
        iss_ok = op_in != NOP && !(op_in >= 5'b10010 && op_in <= 5'b11001);
        for (int i = 0; i < DEPTH; i++) begin
            {q1_n[i], v1_n[i]} = snoop(q1[i], v1[i], alu_num, alu_value, alu_branch, mem_num, mem_value);
            {q2_n[i], v2_n[i]} = snoop(q2[i], v2[i], alu_num, alu_value, alu_branch, mem_num, mem_value);
            if (busy[i] && q1[i] == 3'd0 && q2[i] == 3'd0 && !disp) begin
                disp      = 1'b1;
                d_idx     = IW'(i);
                busy_n[i] = 1'b0;
            end
            if (!busy[i] && !found) begin
                found   = 1'b1;
                iss_idx = IW'(i);
            end
        end
        if (iss_ok && found) begin
            busy_n[iss_idx] = 1'b1;
            br_n[iss_idx]   = is_branch_in;
            op_n[iss_idx]   = op_in;
            imm_n[iss_idx]  = imm_in;
            dest_n[iss_idx] = target_in;
            {q1_n[iss_idx], v1_n[iss_idx]} = snoop(query1_in, value1_in, alu_num, alu_value, alu_branch, mem_num, mem_value);
            {q2_n[iss_idx], v2_n[iss_idx]} = snoop(query2_in, value2_in, alu_num, alu_value, alu_branch, mem_num, mem_value);
        end
        for (int i = 0; i < DEPTH; i++)
            occ = occ + (busy_n[i] ? 1 : 0);
    end

    always_ff @(posedge clk) begin
        br   <= br_n;
        op   <= op_n;
        v1   <= v1_n;
        v2   <= v2_n;
        q1   <= q1_n;
        q2   <= q2_n;
        imm  <= imm_n;
        dest <= dest_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            rs_full      <= 1'b0;
            ex_op        <= NOP;
            ex_dest      <= 3'd0;
            ex_a         <= 32'd0;
            ex_b         <= 32'd0;
            ex_imm       <= 32'd0;
            ex_is_branch <= 1'b0;
        end else begin
            busy    <= busy_n;
            rs_full <= occ >= FULL_MARK;
            ex_op   <= disp ? op[d_idx] : NOP;
            ex_dest <= disp ? dest[d_idx] : 3'd0;
            if (disp) begin
                ex_a         <= v1[d_idx];
                ex_b         <= v2[d_idx];
                ex_imm       <= imm[d_idx];
                ex_is_branch <= br[d_idx];
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed stimulus with an expected-dispatch queue checked by an independent monitor.
module tb_reservation_station;
    localparam logic [4:0] NOP = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  op_in;
    logic [31:0] value1_in, value2_in, imm_in, alu_value, mem_value;
    logic [2:0]  query1_in, query2_in, target_in, alu_num, mem_num;
    logic        is_branch_in, alu_branch;
    logic        rs_full, ex_is_branch;
    logic [4:0]  ex_op;
    logic [31:0] ex_a, ex_b, ex_imm;
    logic [2:0]  ex_dest;

    reservation_station #(.DEPTH(4), .FULL_MARK(3)) dut (
        .clk(clk), .rst(rst), .op_in(op_in), .value1_in(value1_in), .value2_in(value2_in),
        .query1_in(query1_in), .query2_in(query2_in), .imm_in(imm_in), .target_in(target_in),
        .is_branch_in(is_branch_in), .alu_num(alu_num), .alu_value(alu_value), .alu_branch(alu_branch),
        .mem_num(mem_num), .mem_value(mem_value), .rs_full(rs_full), .ex_op(ex_op), .ex_a(ex_a),
        .ex_b(ex_b), .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_is_branch(ex_is_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [4:0]  op;
        logic [31:0] a, b, imm;
        logic [2:0]  dest;
        logic        br;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (ex_op !== NOP) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dispatch cyc=%0d got op=%b a=%h b=%h dest=%0d, wanted no dispatch", cyc, ex_op, ex_a, ex_b, ex_dest);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.op !== ex_op || e.a !== ex_a || e.b !== ex_b || e.imm !== ex_imm || e.dest !== ex_dest || e.br !== ex_is_branch) begin
                        errors++;
                        $display("FAIL dispatch got cyc=%0d op=%b a=%h b=%h imm=%h dest=%0d br=%b, wanted cyc=%0d op=%b a=%h b=%h imm=%h dest=%0d br=%b",
                                 cyc, ex_op, ex_a, ex_b, ex_imm, ex_dest, ex_is_branch, e.cyc, e.op, e.a, e.b, e.imm, e.dest, e.br);
                    end
                end
            end else if (ex_dest !== 3'd0) begin
                errors++;
                $display("FAIL idle_dest cyc=%0d got ex_dest=%0d, wanted 0", cyc, ex_dest);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic clear();
        op_in = NOP; value1_in = 0; value2_in = 0; query1_in = 0; query2_in = 0;
        imm_in = 0; target_in = 0; is_branch_in = 0;
        alu_num = 0; alu_value = 0; alu_branch = 0; mem_num = 0; mem_value = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] qa, input logic [2:0] qb, input logic [31:0] im,
                         input logic [2:0] tgt, input logic br);
        op_in = op; value1_in = a; value2_in = b; query1_in = qa; query2_in = qb;
        imm_in = im; target_in = tgt; is_branch_in = br;
    endtask

    task automatic push(input int c, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [2:0] d, input logic br);
        exp_t e;
        e.cyc = c; e.op = op; e.a = a; e.b = b; e.imm = im; e.dest = d; e.br = br;
        exp_q.push_back(e);
    endtask

    initial begin
        int b;
        clear();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_full", {31'd0, rs_full}, 0);
        chk("rst_ex_op", {27'd0, ex_op}, 32'h1f);
        chk("rst_ex_dest", {29'd0, ex_dest}, 0);
        chk("rst_ex_a", ex_a, 0);
        chk("rst_ex_b", ex_b, 0);
        chk("rst_ex_imm", ex_imm, 0);
        chk("rst_ex_br", {31'd0, ex_is_branch}, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        issue(5'b00000, 5, 7, 0, 0, 32'h9, 3, 0);
        push(cyc + 2, 5'b00000, 5, 7, 32'h9, 3, 0);
        tick();
        repeat (3) tick();

        issue(5'b00001, 0, 3, 2, 0, 1, 4, 0);
        push(cyc + 4, 5'b00001, 32'h10, 3, 1, 4, 0);
        tick();
        tick();
        alu_num = 2; alu_value = 32'h10;
        tick();
        repeat (3) tick();

        issue(5'b00010, 1, 0, 0, 5, 2, 5, 0);
        mem_num = 5; mem_value = 32'hABCD;
        push(cyc + 2, 5'b00010, 1, 32'hABCD, 2, 5, 0);
        tick();
        repeat (3) tick();

        issue(5'b00011, 0, 8, 6, 0, 3, 6, 1);
        tick();
        tick();
        alu_num = 6; alu_branch = 1; alu_value = 99;
        tick();
        repeat (3) tick();
        mem_num = 6; mem_value = 32'h66;
        push(cyc + 2, 5'b00011, 32'h66, 8, 3, 6, 1);
        tick();
        repeat (3) tick();

        issue(5'b00100, 0, 9, 7, 0, 4, 7, 0);
        tick();
        alu_num = 7; alu_value = 1; mem_num = 7; mem_value = 2;
        push(cyc + 2, 5'b00100, 2, 9, 4, 7, 0);
        tick();
        repeat (3) tick();

        issue(5'b10010, 1, 1, 0, 0, 0, 1, 0);
        tick();
        issue(5'b11001, 1, 1, 0, 0, 0, 1, 0);
        tick();
        repeat (3) tick();
        chk("ldst_full", {31'd0, rs_full}, 0);

        for (int i = 0; i < 4; i++) begin
            issue(5'(5 + i), 0, 32'(100 + i), 1, 0, 0, 3'(i + 1), 0);
            tick();
            chk($sformatf("fill_%0d", i), {31'd0, rs_full}, {31'd0, i >= 2});
        end
        issue(5'd9, 55, 66, 0, 0, 0, 5, 0);
        tick();
        chk("drop_full", {31'd0, rs_full}, 1);
        mem_num = 1; mem_value = 32'h77;
        b = cyc;
        for (int i = 0; i < 4; i++) push(b + 2 + i, 5'(5 + i), 32'h77, 32'(100 + i), 0, 3'(i + 1), 0);
        tick();
        chk("drain_full0", {31'd0, rs_full}, 1);
        tick();
        chk("drain_full1", {31'd0, rs_full}, 1);
        tick();
        chk("drain_full2", {31'd0, rs_full}, 0);
        repeat (4) tick();

        issue(5'd10, 1, 2, 2, 0, 0, 2, 0);
        tick();
        issue(5'd11, 3, 4, 2, 0, 0, 3, 0);
        tick();
        rst = 1'b1;
        issue(5'd12, 5, 6, 0, 0, 0, 1, 0);
        tick();
        rst = 1'b0;
        chk("mid_rst_full", {31'd0, rs_full}, 0);
        chk("mid_rst_ex_op", {27'd0, ex_op}, 32'h1f);
        chk("mid_rst_ex_a", ex_a, 0);
        chk("mid_rst_ex_dest", {29'd0, ex_dest}, 0);
        alu_num = 2; alu_value = 5;
        tick();
        mem_num = 3; mem_value = 6;
        tick();
        repeat (5) tick();

        chk("drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have these parameters (name, default, meaning): DEPTH, 4, number of entries; FULL_MARK, 3, occupancy at which rs_full asserts.
REQ-002 SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- op_in  in  5  issued opcode; 5'b11111 means no issue.
- value1_in  in  32  source-1 value.
- value2_in  in  32  source-2 value.
- query1_in  in  3  ROB tag source 1 waits on; 0 means value1_in is valid.
- query2_in  in  3  ROB tag source 2 waits on; 0 means value2_in is valid.
- imm_in  in  32  immediate.
- target_in  in  3  destination ROB tag, 1..7.
- is_branch_in  in  1  issued op is a conditional branch.
- alu_num  in  3  ALU CDB tag; 0 means idle.
- alu_value  in  32  ALU CDB value.
- alu_branch  in  1  ALU CDB carries a branch outcome, not data.
- mem_num  in  3  memory CDB tag; 0 means idle.
- mem_value  in  32  memory CDB value.
- rs_full  out  1  registered backpressure to the ROB.
- ex_op  out  5  dispatched opcode; 5'b11111 means none.
- ex_a  out  32  operand 1.
- ex_b  out  32  operand 2.
- ex_imm  out  32  immediate.
- ex_dest  out  3  ROB tag of the dispatched op; 0 means none.
- ex_is_branch  out  1  dispatched op is a branch.

Function
REQ-003 SHALL hold per entry: busy, op, v1, v2, q1, q2, imm, dest, is_branch.
REQ-004 SHALL accept an issue when op_in != 5'b11111 and op_in is not a load/store (5'b10010..5'b11001). It writes the lowest-index free entry on that posedge.
REQ-005 SHALL silently drop an issue when no entry is free; rs_full is the contract that prevents this.
REQ-006 SHALL snoop both CDBs every cycle:
- a busy entry with q1 or q2 equal to a nonzero broadcast tag takes that value into v1/v2;
- the matching q is then cleared to 0.
REQ-007 SHALL ignore the ALU CDB for snooping when alu_branch=1.
REQ-008 SHALL apply the CDB to an issue arriving in the same cycle. If query1_in or query2_in matches alu_num or mem_num, the entry is written with the broadcast value and q=0.
REQ-009 SHALL, if alu_num == mem_num (nonzero), use mem_value.
REQ-010 SHALL treat an entry as ready when busy, q1==0 and q2==0.
REQ-011 SHALL dispatch at most one ready entry per cycle, choosing the lowest index. The entry is freed, and the ex_* registers are loaded on that posedge.
REQ-012 SHALL dispatch an entry no earlier than the posedge after the one that wrote it. Minimum issue-to-ex_op latency is 2 posedges; the ex_* outputs are valid after the second.
REQ-013 SHALL NOT make an entry freed by dispatch available for issue until the following cycle.
REQ-014 SHALL drive ex_op=5'b11111 and ex_dest=0 in every cycle with no dispatch; the other ex_* outputs hold their values.
REQ-015 SHALL register rs_full = (occupancy after this posedge's issue and dispatch >= FULL_MARK).
REQ-016 SHALL keep occupancy within 0..DEPTH with no wrap; simultaneous issue and dispatch leaves it unchanged.

Reset
REQ-017 SHALL, with rst high at a posedge, clear all busy bits and set: rs_full=0, ex_op=5'b11111, ex_dest=0, ex_a=0, ex_b=0, ex_imm=0, ex_is_branch=0.
REQ-018 SHALL have rst override any issue, CDB or dispatch in the same cycle, including a reset during partial occupancy.

Verification
REQ-019 SHALL pass these directed scenarios:
- Issue ADD (5'b00000), q1=q2=0, v1=5, v2=7, target=3 -> two posedges later ex_op=00000, ex_a=5, ex_b=7, ex_dest=3; the next cycle ex_op=11111.
- Issue SUB, q1=2, target=4; alu_num=2, alu_value=0x10 two cycles later -> SUB dispatches the posedge after the broadcast with ex_a=0x10.
- Issue with q2=5 while mem_num=5, mem_value=0xABCD in the same cycle -> the entry is ready immediately and dispatches the next posedge with ex_b=0xABCD.
- alu_num=6, alu_branch=1 while an entry waits on q1=6 -> the entry stays waiting.
- Issue 3 entries with unresolved q and no dispatch -> rs_full=1 after the 3rd posedge. A 4th issue fills the array. A 5th issue is dropped, and occupancy stays 4.
- rst high with 2 busy entries -> next cycle rs_full=0 and ex_op=11111. A subsequent broadcast of the old tags causes no dispatch.
